sdram_block_mover: RTL

- Client-side initiator for the SDRAM controller's word request interface; it drives the rd/wt strobe/ack handshakes that the controller responds to.
- Accepts a block command (start address, word count, direction) and splits it into single-word controller requests with linear address increment.
- Writes take words from a valid/ready source stream; reads deliver words to a valid/ready sink stream.
- Sits between the user datapath (DMA, frame buffer logic) and the controller; one transfer in flight at a time.

---
 rtl/sdram_block_mover_if.sv | 47 ++++
 rtl/sdram_block_mover.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/sdram_block_mover_if.sv
// rtl/sdram_block_mover_if.sv - command, stream and controller request bundle for the block mover
interface sdram_block_mover_if #(
    parameter int DATA_WIDTH = 16,
    parameter int ADR_WIDTH  = 24,
    parameter int LEN_WIDTH  = 16
);
    logic                  cmd_valid;
    logic                  cmd_ready;
    logic                  cmd_write;
    logic [ADR_WIDTH-1:0]  cmd_addr;
    logic [LEN_WIDTH-1:0]  cmd_len;
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  wr_valid;
    logic                  wr_ready;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  rd_valid;
    logic                  rd_ready;
    logic                  done;
    logic                  err;
    logic                  wt_i_stb;
    logic                  wt_i_ack;
    logic                  wt_o_stb;
    logic                  wt_o_ack;
    logic [ADR_WIDTH-1:0]  WT_ADR;
    logic [DATA_WIDTH-1:0] WT_DATA;
    logic                  rd_i_stb;
    logic                  rd_i_ack;
    logic                  rd_o_stb;
    logic                  rd_o_ack;
    logic [ADR_WIDTH-1:0]  RD_ADR;
    logic [DATA_WIDTH-1:0] RD_DATA;

    // master is the block mover itself; slave is the user datapath plus SDRAM controller
    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_len, wr_data, wr_valid, rd_ready,
               wt_i_ack, wt_o_stb, rd_i_ack, rd_o_stb, RD_DATA,
        output cmd_ready, wr_ready, rd_data, rd_valid, done, err,
               wt_i_stb, wt_o_ack, WT_ADR, WT_DATA, rd_i_stb, rd_o_ack, RD_ADR
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_len, wr_data, wr_valid, rd_ready,
               wt_i_ack, wt_o_stb, rd_i_ack, rd_o_stb, RD_DATA,
        input  cmd_ready, wr_ready, rd_data, rd_valid, done, err,
               wt_i_stb, wt_o_ack, WT_ADR, WT_DATA, rd_i_stb, rd_o_ack, RD_ADR
    );
endinterface

// File: rtl/sdram_block_mover.sv
// rtl/sdram_block_mover.sv - splits block commands into single-word SDRAM controller requests
module sdram_block_mover #(
    parameter int DATA_WIDTH = 16,
    parameter int ADR_WIDTH  = 24,
    parameter int LEN_WIDTH  = 16,
    parameter int TIMEOUT    = 255
) (
    input logic                 CLK,
    input logic                 RST,
    sdram_block_mover_if.master bus
);
    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_FETCH   = 3'd1;
    localparam logic [2:0] S_REQ     = 3'd2;
    localparam logic [2:0] S_WAIT    = 3'd3;
    localparam logic [2:0] S_DELIVER = 3'd4;
    localparam logic [2:0] S_FIN     = 3'd5;

    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

    logic [2:0]            state_q, state_d;
    logic [ADR_WIDTH-1:0]  addr_q, addr_d;
    logic [LEN_WIDTH-1:0]  len_q, len_d;
    logic                  write_q, write_d;
    logic                  err_flag_q, err_flag_d;
    logic [15:0]           tmo_q, tmo_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                  wt_stb_q, wt_stb_d;
    logic                  rd_stb_q, rd_stb_d;

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        len_d      = len_q;
        write_d    = write_q;
        err_flag_d = err_flag_q;
        tmo_d      = tmo_q;
        wdata_d    = wdata_q;
        rdata_d    = rdata_q;

        case (state_q)
            S_IDLE: begin
                if (bus.cmd_valid) begin
                    addr_d     = bus.cmd_addr;
                    len_d      = bus.cmd_len;
                    write_d    = bus.cmd_write;
                    err_flag_d = 1'b0;
                    if (bus.cmd_len == '0)
                        state_d = S_FIN;
                    else if (bus.cmd_write)
                        state_d = S_FETCH;
                    else
                        state_d = S_REQ;
                end
            end
            S_FETCH: begin
                if (bus.wr_valid) begin
                    wdata_d = bus.wr_data;
                    state_d = S_REQ;
                end
            end
            S_REQ: begin
                if (write_q ? bus.wt_i_ack : bus.rd_i_ack) begin
                    tmo_d   = '0;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                // a completion beats a timeout landing in the same cycle
                if (write_q && bus.wt_o_stb) begin
                    len_d = len_q - 1'b1;
                    if (len_q == LEN_WIDTH'(1)) begin
                        state_d = S_FIN;
                    end else begin
                        addr_d  = addr_q + 1'b1;
                        state_d = S_FETCH;
                    end
                end else if (!write_q && bus.rd_o_stb) begin
                    rdata_d = bus.RD_DATA;
                    state_d = S_DELIVER;
                end else if (tmo_q == TMO_LAST) begin
                    err_flag_d = 1'b1;
                    state_d    = S_FIN;
                end else begin
                    tmo_d = tmo_q + 16'd1;
                end
            end
            S_DELIVER: begin
                if (bus.rd_ready) begin
                    len_d = len_q - 1'b1;
                    if (len_q == LEN_WIDTH'(1)) begin
                        state_d = S_FIN;
                    end else begin
                        addr_d  = addr_q + 1'b1;
                        state_d = S_REQ;
                    end
                end
            end
            S_FIN:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // strobes are flops so they rise on the first REQ cycle and fall right after the ack edge
        wt_stb_d = (state_d == S_REQ) && write_d;
        rd_stb_d = (state_d == S_REQ) && !write_d;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= S_IDLE;
            addr_q     <= '0;
            len_q      <= '0;
            write_q    <= 1'b0;
            err_flag_q <= 1'b0;
            tmo_q      <= '0;
            wdata_q    <= '0;
            rdata_q    <= '0;
            wt_stb_q   <= 1'b0;
            rd_stb_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            len_q      <= len_d;
            write_q    <= write_d;
            err_flag_q <= err_flag_d;
            tmo_q      <= tmo_d;
            wdata_q    <= wdata_d;
            rdata_q    <= rdata_d;
            wt_stb_q   <= wt_stb_d;
            rd_stb_q   <= rd_stb_d;
        end
    end

    assign bus.cmd_ready = (state_q == S_IDLE);
    assign bus.wr_ready  = (state_q == S_FETCH);
    assign bus.rd_valid  = (state_q == S_DELIVER);
    assign bus.rd_data   = rdata_q;
    assign bus.done      = (state_q == S_FIN);
    assign bus.err       = (state_q == S_FIN) && err_flag_q;
    assign bus.wt_i_stb  = wt_stb_q;
    assign bus.rd_i_stb  = rd_stb_q;
    assign bus.wt_o_ack  = (state_q == S_WAIT) && write_q && bus.wt_o_stb;
    assign bus.rd_o_ack  = (state_q == S_WAIT) && !write_q && bus.rd_o_stb;
    assign bus.WT_ADR    = write_q ? addr_q : '0;
    assign bus.RD_ADR    = write_q ? '0 : addr_q;
    assign bus.WT_DATA   = wdata_q;
endmodule
